// File: rtl/snake_pkg.sv
// snake_pkg -- definitions shared by the game overlay blocks.
//   Pitch/icon-size defaults used by score_overlay.
//   4-bit-per-channel colour constants (RED, GOLD, GREY).
//   Flash FSM state type and a score saturation helper.
package snake_pkg;

  localparam int PITCH_LOG2_DEF = 5;
  localparam int ICON_SIZE_DEF  = 28;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RED  = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb_t GOLD = '{r: 4'hF, g: 4'hC, b: 4'h0};
  localparam rgb_t GREY = '{r: 4'h8, g: 4'h8, b: 4'h8};

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  // Clamp the live score to the number of icons that can be drawn.
  function automatic logic [5:0] sat_points(input logic [5:0] p, input int max_icons);
    return (int'(p) > max_icons) ? 6'(max_icons) : p;
  endfunction

endpackage

// File: rtl/score_flash_fsm.sv
// score_flash_fsm -- per-frame score latch and newest-icon blink controller.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   frame_start     one-cycle pulse at the first pixel of a frame
//   points_sat      live score already clamped to the icon limit
//   shown_pts       score latched at the last frame_start
//   new_idx         index of the icon that is blinking
//   blank_en        high while the blinking icon is in its "off" phase
module score_flash_fsm
  import snake_pkg::*;
#(
  parameter int FLASH_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [5:0] points_sat,
  output logic [5:0] shown_pts,
  output logic [5:0] new_idx,
  output logic       blank_en
);

  flash_state_t state, state_n;
  logic [7:0]   flash_cnt, cnt_n;
  logic [5:0]   shown_n, idx_n;
  logic         loaded, loaded_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flash_cnt <= '0;
      shown_pts <= '0;
      new_idx   <= '0;
      loaded    <= 1'b0;
    end else begin
      state     <= state_n;
      flash_cnt <= cnt_n;
      shown_pts <= shown_n;
      new_idx   <= idx_n;
      loaded    <= loaded_n;
    end
  end

  // The first frame after reset only loads the score: an already-nonzero
  // score is not a "new" point, so it must not start a blink.
  always_comb begin
    state_n  = state;
    cnt_n    = flash_cnt;
    shown_n  = shown_pts;
    idx_n    = new_idx;
    loaded_n = loaded;
    if (frame_start) begin
      loaded_n = 1'b1;
      shown_n  = points_sat;
      if (!loaded) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (points_sat > shown_pts) begin
        state_n = FLASH;
        cnt_n   = 8'(FLASH_FRAMES);
        idx_n   = points_sat - 6'd1;
      end else if (points_sat < shown_pts) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (state == FLASH) begin
        cnt_n = flash_cnt - 8'd1;
        if (cnt_n == '0) begin
          state_n = IDLE;
        end
      end
    end
  end

  // Bit 2 of the countdown toggles every four frames: 4 on / 4 off.
  assign blank_en = (state == FLASH) && flash_cnt[2];

endmodule

// File: rtl/score_overlay.sv
// score_overlay -- draws one square icon per scored point over the video.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   frame_start         one-cycle pulse at the first pixel of a frame
//   pix_valid           curr_x/curr_y valid this cycle
//   curr_x, curr_y      current pixel coordinate (11 bits)
//   points              live score (sampled once per frame)
//   lose, win           game-end colour modes (win has priority)
//   hit                 pixel lies inside a drawn icon (2-cycle latency)
//   out_valid           pix_valid aligned with hit/draw_*
//   draw_r/g/b          icon colour, zero when hit is low
module score_overlay
  import snake_pkg::*;
#(
  parameter int MAX_ICONS     = 32,
  parameter int ICONS_PER_ROW = 16,
  parameter int PITCH_LOG2    = PITCH_LOG2_DEF,
  parameter int ICON_SIZE     = ICON_SIZE_DEF,
  parameter int X_OFF         = 20,
  parameter int Y_OFF         = 20,
  parameter int FLASH_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [10:0] curr_x,
  input  logic [10:0] curr_y,
  input  logic [5:0]  points,
  input  logic        lose,
  input  logic        win,
  output logic        hit,
  output logic        out_valid,
  output logic [3:0]  draw_r,
  output logic [3:0]  draw_g,
  output logic [3:0]  draw_b
);

  // Extra top bit so ICON_SIZE == pitch still compares correctly.
  localparam logic [PITCH_LOG2:0] ICON_LIM = (PITCH_LOG2 + 1)'(ICON_SIZE);

  logic [5:0] points_sat, shown_pts, new_idx;
  logic       blank_en;

  assign points_sat = sat_points(points, MAX_ICONS);

  score_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .points_sat (points_sat),
    .shown_pts  (shown_pts),
    .new_idx    (new_idx),
    .blank_en   (blank_en)
  );

  // Stage 1: offset into icon space; a borrow into bit 11 means the pixel
  // is above or left of icon 0.
  logic [11:0] rel_x, rel_y;
  assign rel_x = {1'b0, curr_x} - 12'(X_OFF);
  assign rel_y = {1'b0, curr_y} - 12'(Y_OFF);

  logic                  s1_valid, s1_miss, s1_win, s1_lose;
  logic [10:0]           s1_col, s1_row;
  logic [PITCH_LOG2-1:0] s1_ox, s1_oy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_miss  <= 1'b0;
      s1_win   <= 1'b0;
      s1_lose  <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_ox    <= '0;
      s1_oy    <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_miss  <= rel_x[11] | rel_y[11];
      s1_win   <= win;
      s1_lose  <= lose;
      s1_col   <= rel_x[10:0] >> PITCH_LOG2;
      s1_row   <= rel_y[10:0] >> PITCH_LOG2;
      s1_ox    <= rel_x[PITCH_LOG2-1:0];
      s1_oy    <= rel_y[PITCH_LOG2-1:0];
    end
  end

  // Stage 2: icon index and hit test. shown_pts/blank already reflect a
  // frame_start that arrived with this pixel, since it was sampled a cycle
  // earlier than this stage evaluates.
  logic [21:0] idx;
  logic        blank, hit_d;
  rgb_t        colour;

  assign idx   = 22'(s1_row) * 22'(ICONS_PER_ROW) + 22'(s1_col);
  assign blank = blank_en && (idx == 22'(new_idx));
  assign hit_d = s1_valid && !s1_miss
              && (s1_col < 11'(ICONS_PER_ROW))
              && ({1'b0, s1_ox} < ICON_LIM)
              && ({1'b0, s1_oy} < ICON_LIM)
              && (idx < 22'(shown_pts))
              && !blank;
  assign colour = s1_win ? GOLD : (s1_lose ? GREY : RED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      draw_r    <= '0;
      draw_g    <= '0;
      draw_b    <= '0;
    end else begin
      out_valid <= s1_valid;
      hit       <= hit_d;
      draw_r    <= hit_d ? colour.r : 4'h0;
      draw_g    <= hit_d ? colour.g : 4'h0;
      draw_b    <= hit_d ? colour.b : 4'h0;
    end
  end

endmodule

// File: tb/tb_score_overlay.sv
// tb_score_overlay -- randomized and directed bench for score_overlay with a
// geometric reference model of the icon grid and per-frame score rules.
module tb_score_overlay;

  localparam int MAX_ICONS    = 32;
  localparam int IPR          = 16;
  localparam int PITCH        = 32;
  localparam int ICON_SIZE    = 28;
  localparam int X_OFF        = 20;
  localparam int Y_OFF        = 20;
  localparam int FLASH_FRAMES = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [10:0] curr_x = '0;
  logic [10:0] curr_y = '0;
  logic [5:0]  points = '0;
  logic        lose = 1'b0;
  logic        win = 1'b0;
  logic        hit, out_valid;
  logic [3:0]  draw_r, draw_g, draw_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: score shown this frame and remaining blink frames.
  int m_shown, m_flash_left, m_newest;
  bit m_loaded;

  // Expected output of the pixel driven in the current step (pend) and of
  // the pixel whose result is visible now (exp).
  logic [13:0] pend_out, exp_out;
  int pend_x, pend_y, exp_x, exp_y;

  score_overlay #(
    .MAX_ICONS    (MAX_ICONS),
    .ICONS_PER_ROW(IPR),
    .PITCH_LOG2   (5),
    .ICON_SIZE    (ICON_SIZE),
    .X_OFF        (X_OFF),
    .Y_OFF        (Y_OFF),
    .FLASH_FRAMES (FLASH_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .points     (points),
    .lose       (lose),
    .win        (win),
    .hit        (hit),
    .out_valid  (out_valid),
    .draw_r     (draw_r),
    .draw_g     (draw_g),
    .draw_b     (draw_b)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] observed();
    return {out_valid, hit, draw_r, draw_g, draw_b};
  endfunction

  function automatic void model_reset();
    m_shown = 0; m_flash_left = 0; m_newest = 0; m_loaded = 1'b0;
    pend_out = '0; exp_out = '0;
    pend_x = 0; pend_y = 0; exp_x = 0; exp_y = 0;
  endfunction

  // Frame boundary: latch the clamped score and advance the blink countdown.
  function automatic void model_frame(input int p);
    int sat;
    sat = (p > MAX_ICONS) ? MAX_ICONS : p;
    if (!m_loaded) begin
      m_loaded = 1'b1; m_shown = sat; m_flash_left = 0;
    end else if (sat > m_shown) begin
      m_flash_left = FLASH_FRAMES; m_newest = sat - 1; m_shown = sat;
    end else if (sat < m_shown) begin
      m_shown = sat; m_flash_left = 0;
    end else if (m_flash_left > 0) begin
      m_flash_left--;
    end
  endfunction

  // Walk the shown icons as rectangles on screen.
  function automatic bit model_hit(input int x, input int y);
    bit blank_on;
    int ix, iy;
    blank_on = (m_flash_left > 0) && (((m_flash_left / 4) % 2) == 1);
    for (int i = 0; i < m_shown; i++) begin
      ix = X_OFF + (i % IPR) * PITCH;
      iy = Y_OFF + (i / IPR) * PITCH;
      if (x >= ix && x < ix + ICON_SIZE && y >= iy && y < iy + ICON_SIZE)
        return !(blank_on && i == m_newest);
    end
    return 1'b0;
  endfunction

  // Drive one pixel for one clock; afterwards exp_* describes what the DUT
  // outputs are showing now (the pixel driven one step earlier).
  task automatic step_pixel(input int x, input int y, input bit v, input bit fs);
    bit h;
    logic [11:0] c;
    if (fs) model_frame(int'(points));
    h = v && model_hit(x, y);
    c = !h ? 12'h000 : (win ? 12'hFC0 : (lose ? 12'h888 : 12'hF00));
    curr_x = 11'(x); curr_y = 11'(y); pix_valid = v; frame_start = fs;
    @(posedge clk); #1;
    exp_out = pend_out; exp_x = pend_x; exp_y = pend_y;
    pend_out = {v, h, c}; pend_x = x; pend_y = y;
  endtask

  task automatic do_reset();
    rst = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; pix_valid = 1'b1; frame_start = 1'b1;
    curr_x = 11'd30; curr_y = 11'd30; points = 6'd5;
    repeat (3) @(posedge clk);
    #1;
    if (observed() !== 14'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h, expected 0", observed());
    end
    checks++;
    if (dut.shown_pts !== 6'd0) begin
      errors++; $display("[TB] FAIL reset_shown: got %0d, expected 0", dut.shown_pts);
    end
    checks++;
    if (dut.u_fsm.state !== snake_pkg::IDLE) begin
      errors++; $display("[TB] FAIL reset_state: got %0d, expected IDLE", dut.u_fsm.state);
    end
    checks++;
    pix_valid = 1'b0; frame_start = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_row_scan();
    int hits = 0;
    points = 6'd3; win = 1'b0; lose = 1'b0;
    step_pixel(0, 0, 1'b0, 1'b1);
    for (int x = 0; x <= 153; x++) begin
      step_pixel(x, 30, x <= 152, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL row_scan x=%0d: got %h, expected %h", exp_x, observed(), exp_out);
      end
      checks++;
      if (hit === 1'b1) hits++;
    end
    if (hits != 84) begin
      errors++; $display("[TB] FAIL row_scan_count: got %0d, expected 84", hits);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int hits = 0;
    do_reset();
    points = 6'd17;
    step_pixel(0, 0, 1'b0, 1'b1);
    for (int x = 0; x <= 61; x++) begin
      step_pixel(x, 60, x <= 60, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL wrap x=%0d y=60: got %h, expected %h", exp_x, observed(), exp_out);
      end
      checks++;
      if (hit === 1'b1) hits++;
    end
    for (int x = 500; x <= 561; x++) begin
      step_pixel(x, 30, x <= 560, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL wrap x=%0d y=%0d: got %h, expected %h", exp_x, exp_y, observed(), exp_out);
      end
      checks++;
      if (hit === 1'b1) hits++;
    end
    if (hits != 56) begin
      errors++; $display("[TB] FAIL wrap_count: got %0d, expected 56", hits);
    end
    checks++;
  endtask

  task automatic test_flash();
    int blanked = 0;
    do_reset();
    points = 6'd3;
    step_pixel(0, 0, 1'b0, 1'b1);
    points = 6'd4;
    for (int f = 0; f < 34; f++) begin
      step_pixel(0, 0, 1'b0, 1'b1);
      step_pixel(120, 30, 1'b1, 1'b0);
      step_pixel(30, 30, 1'b1, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL flash f=%0d x=120: got %h, expected %h", f, observed(), exp_out);
      end
      checks++;
      if (hit !== 1'b1) blanked++;
      step_pixel(0, 0, 1'b0, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL flash f=%0d x=30: got %h, expected %h", f, observed(), exp_out);
      end
      checks++;
    end
    if (blanked != 15) begin
      errors++; $display("[TB] FAIL flash_blank_frames: got %0d, expected 15", blanked);
    end
    checks++;
    if (dut.u_fsm.state !== snake_pkg::IDLE) begin
      errors++; $display("[TB] FAIL flash_end_state: got %0d, expected IDLE", dut.u_fsm.state);
    end
    checks++;
  endtask

  task automatic test_mid_frame();
    int late = 0;
    int hits = 0;
    do_reset();
    points = 6'd5;
    step_pixel(0, 0, 1'b0, 1'b1);
    for (int x = 0; x <= 221; x++) begin
      if (x == 100) points = 6'd6;
      step_pixel(x, 30, x <= 220, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL mid_frame x=%0d: got %h, expected %h", exp_x, observed(), exp_out);
      end
      checks++;
      if (exp_x >= 180 && exp_x <= 207 && hit === 1'b1) late++;
    end
    if (late != 0) begin
      errors++; $display("[TB] FAIL mid_frame_icon5: got %0d hits, expected 0", late);
    end
    checks++;
    // Four frames in, the blink countdown is 27 and icon 5 is in its "on" phase.
    for (int f = 0; f < 4; f++) begin
      step_pixel(0, 0, 1'b0, 1'b1);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL mid_frame_fs: got %h, expected %h", observed(), exp_out);
      end
      checks++;
    end
    for (int x = 0; x <= 221; x++) begin
      step_pixel(x, 30, x <= 220, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL next_frame x=%0d: got %h, expected %h", exp_x, observed(), exp_out);
      end
      checks++;
      if (hit === 1'b1) hits++;
    end
    if (hits != 168) begin
      errors++; $display("[TB] FAIL next_frame_count: got %0d, expected 168", hits);
    end
    checks++;
  endtask

  task automatic test_win_lose();
    int hits[3] = '{0, 0, 0};
    int ys[3] = '{30, 62, 94};
    do_reset();
    win = 1'b1; lose = 1'b1; points = 6'd40;
    step_pixel(0, 0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x <= 562; x += 2) begin
        step_pixel(x, ys[r], x <= 560, 1'b0);
        if (observed() !== exp_out) begin
          errors++; $display("[TB] FAIL win_lose x=%0d y=%0d: got %h, expected %h", exp_x, exp_y, observed(), exp_out);
        end
        checks++;
        if (hit === 1'b1 && exp_y == ys[r]) hits[r]++;
        if (exp_x == 30 && exp_y == 30 && {draw_r, draw_g, draw_b} !== 12'hFC0) begin
          errors++; $display("[TB] FAIL gold_colour: got %h, expected fc0", {draw_r, draw_g, draw_b});
        end
        if (exp_x == 30 && exp_y == 30) checks++;
      end
    end
    if (hits[0] != 224 || hits[1] != 224 || hits[2] != 0) begin
      errors++; $display("[TB] FAIL saturate_rows: got %0d/%0d/%0d, expected 224/224/0", hits[0], hits[1], hits[2]);
    end
    checks++;
    for (int m = 0; m < 2; m++) begin
      win = 1'b0; lose = (m == 0);
      for (int x = 8; x <= 32; x++) begin
        step_pixel(x, 30, 1'b1, 1'b0);
        if (observed() !== exp_out) begin
          errors++; $display("[TB] FAIL colour_mode%0d x=%0d: got %h, expected %h", m, exp_x, observed(), exp_out);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    do_reset();
    points = 6'd8; win = 1'b0; lose = 1'b0;
    step_pixel(0, 0, 1'b0, 1'b1);
    for (int x = 20; x < 30; x++) begin
      step_pixel(x, 30, 1'b1, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL pre_reset x=%0d: got %h, expected %h", exp_x, observed(), exp_out);
      end
      checks++;
    end
    #3;
    rst = 1'b0;
    #1;
    if (observed() !== 14'h0) begin
      errors++; $display("[TB] FAIL async_reset: got %h, expected 0", observed());
    end
    checks++;
    pix_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    for (int x = 0; x <= 61; x++) begin
      step_pixel(x, 30, x <= 60, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL post_reset x=%0d: got %h, expected %h", exp_x, observed(), exp_out);
      end
      checks++;
      if (hit === 1'b1) hits++;
    end
    if (hits != 0 || dut.shown_pts !== 6'd0) begin
      errors++; $display("[TB] FAIL post_reset_shown: got %0d hits shown=%0d, expected 0 and 0", hits, dut.shown_pts);
    end
    checks++;
    step_pixel(0, 0, 1'b0, 1'b1);
    for (int x = 18; x <= 50; x++) begin
      step_pixel(x, 30, 1'b1, 1'b0);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL reload x=%0d: got %h, expected %h", exp_x, observed(), exp_out);
      end
      checks++;
    end
    if (dut.u_fsm.state !== snake_pkg::IDLE) begin
      errors++; $display("[TB] FAIL reload_no_flash: got %0d, expected IDLE", dut.u_fsm.state);
    end
    checks++;
  endtask

  task automatic test_random();
    bit fs;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      fs = (i == 0) || ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) points = 6'($urandom_range(0, 63));
      win  = 1'($urandom_range(0, 1));
      lose = 1'($urandom_range(0, 1));
      step_pixel(int'($urandom_range(0, 600)), int'($urandom_range(0, 120)),
                 $urandom_range(0, 3) != 0, fs);
      if (observed() !== exp_out) begin
        errors++; $display("[TB] FAIL random i=%0d x=%0d y=%0d: got %h, expected %h", i, exp_x, exp_y, observed(), exp_out);
      end
      checks++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_row_scan();
    test_wrap();
    test_flash();
    test_mid_frame();
    test_win_lose();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
